ysyx_24100005_lsu: RTL

Parametrised load/store unit between the execute stage and the data-memory port of the NPC core. It accepts one load/store per handshake and drives a valid/ready memory request. It waits for the memory response with a timeout, then returns lane-extracted, sign/zero-extended load data (or a store acknowledge) on a valid/ready response channel. It replaces the single-cycle, always-word read path with a multi-cycle, byte-strobed, handshaked access.

---
 rtl/ysyx_24100005_lsu.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ysyx_24100005_lsu.sv
// rtl/ysyx_24100005_lsu.sv - handshaked load/store unit with byte strobes, load extension and WAIT timeout
// Optional misalignment trap: define YSYX_24100005_LSU_MISALIGN_EN.
module ysyx_24100005_lsu #(
    parameter int XLEN        = 32,
    parameter int STRB_W      = XLEN / 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_addr,
    output logic              mem_wen,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err
);

    localparam int OFF_W = $clog2(STRB_W);
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        f3_q;
    logic [OFF_W-1:0]  off_q;
    logic              req_ready_q;
    logic              mem_req_valid_q;
    logic [XLEN-1:0]   mem_addr_q;
    logic              mem_wen_q;
    logic [STRB_W-1:0] mem_wstrb_q;
    logic [XLEN-1:0]   mem_wdata_q;
    logic              rsp_valid_q;
    logic [XLEN-1:0]   rsp_rdata_q;
    logic              rsp_err_q;

    logic [OFF_W-1:0]  off_d;
    logic [STRB_W-1:0] strb_d;
    logic [XLEN-1:0]   wdata_d;
    logic [XLEN-1:0]   addr_d;
    logic              illegal_d;
    logic              misalign_d;
    logic [XLEN-1:0]   word_d;
    logic [XLEN-1:0]   ext_d;

    always_comb begin
        off_d   = req_addr[OFF_W-1:0];
        addr_d  = {req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
        wdata_d = req_wdata << {off_d, 3'b000};
        case (req_funct3[1:0])
            2'b00:   strb_d = STRB_W'(1)  << off_d;
            2'b01:   strb_d = STRB_W'(3)  << off_d;
            2'b10:   strb_d = STRB_W'(15) << off_d;
            default: strb_d = '1;
        endcase
        illegal_d = (req_funct3 == 3'b111) || (req_wen && req_funct3[2]) ||
                    ((XLEN == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)));
`ifdef YSYX_24100005_LSU_MISALIGN_EN
        misalign_d = |(off_d & OFF_W'((4'd1 << req_funct3[1:0]) - 4'd1));
`else
        misalign_d = 1'b0;
`endif
    end

    // Load extraction works off the offset/size latched at accept time.
    always_comb begin
        word_d = mem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ext_d = XLEN'($signed(word_d[7:0]));
            3'b001:  ext_d = XLEN'($signed(word_d[15:0]));
            3'b010:  ext_d = XLEN'($signed(word_d[31:0]));
            3'b011:  ext_d = word_d;
            3'b100:  ext_d = XLEN'(word_d[7:0]);
            3'b101:  ext_d = XLEN'(word_d[15:0]);
            3'b110:  ext_d = XLEN'(word_d[31:0]);
            default: ext_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            f3_q            <= '0;
            off_q           <= '0;
            req_ready_q     <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= '0;
            mem_wen_q       <= 1'b0;
            mem_wstrb_q     <= '0;
            mem_wdata_q     <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_rdata_q     <= '0;
            rsp_err_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        f3_q        <= req_funct3;
                        off_q       <= off_d;
                        mem_addr_q  <= addr_d;
                        mem_wen_q   <= req_wen;
                        mem_wstrb_q <= req_wen ? strb_d : '0;
                        mem_wdata_q <= wdata_d;
                        if (illegal_d || misalign_d) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            state_q         <= S_REQ;
                            mem_req_valid_q <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        cnt_q           <= '0;
                        state_q         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= mem_wen_q ? '0 : ext_d;
                        state_q     <= S_RESP;
                    end else if ((TIMEOUT_CYC != 0) && (cnt_q == TO_LAST)) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wen       = mem_wen_q;
    assign mem_wstrb     = mem_wstrb_q;
    assign mem_wdata     = mem_wdata_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_err       = rsp_err_q;

endmodule
